// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, subtractor FSM states and
// the condition-code flag bundle used by the adder, subtractor and CC register.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    typedef struct packed {
        logic overflow;
        logic zf;
        logic sf;
    } flags_t;

endpackage

// File: rtl/sub64_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential subtractor.
// Optional macro SUB64_BORROW_OUT_EN adds the unsigned borrow flag.
interface sub64_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             overflow;
    logic             zf;
    logic             sf;
`ifdef SUB64_BORROW_OUT_EN
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, overflow, zf, sf, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, overflow, zf, sf, borrow
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, overflow, zf, sf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, overflow, zf, sf
    );
`endif

endinterface

// File: rtl/sub_digit.sv
// Combinational DIGIT_W-bit adder slice with carry in/out.
module sub_digit #(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    // Ripple sum of one digit; subtraction comes from the caller feeding ~b and cin=1.
    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    end

endmodule

// File: rtl/sub64_seq.sv
// Multi-cycle two's-complement subtractor: diff = a - b, DIGIT_W bits per clock.
// Optional macro SUB64_BORROW_OUT_EN drives bus.borrow = unsigned (a < b).
module sub64_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned DIGIT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    sub64_seq_if.slave  bus
);

    localparam int unsigned N  = WIDTH / DIGIT_W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] nb_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    flags_t           flags_q;
`ifdef SUB64_BORROW_OUT_EN
    logic             borrow_q;
`endif

    logic [DIGIT_W-1:0] slice_s;
    logic               slice_cout;
    logic [WIDTH-1:0]   acc_next;

    sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .x    (a_sh_q[DIGIT_W-1:0]),
        .y    (nb_sh_q[DIGIT_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New slice enters at the MSB end so the result is aligned after N slices.
    always_comb begin
        acc_next = (acc_q >> DIGIT_W) | (WIDTH'(slice_s) << (WIDTH - DIGIT_W));
    end

    // Handshake FSM, slice datapath and completion-time result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            nb_sh_q  <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            flags_q  <= '0;
`ifdef SUB64_BORROW_OUT_EN
            borrow_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        nb_sh_q <= ~bus.b;
                        a_msb_q <= bus.a[WIDTH-1];
                        b_msb_q <= bus.b[WIDTH-1];
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    a_sh_q  <= a_sh_q >> DIGIT_W;
                    nb_sh_q <= nb_sh_q >> DIGIT_W;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q          <= DONE;
                        busy_q           <= 1'b0;
                        done_q           <= 1'b1;
                        diff_q           <= acc_next;
                        flags_q.overflow <= (a_msb_q != b_msb_q) &&
                                            (acc_next[WIDTH-1] != a_msb_q);
                        flags_q.zf       <= (acc_next == '0);
                        flags_q.sf       <= acc_next[WIDTH-1];
`ifdef SUB64_BORROW_OUT_EN
                        borrow_q         <= ~slice_cout;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.overflow = flags_q.overflow;
    assign bus.zf       = flags_q.zf;
    assign bus.sf       = flags_q.sf;
`ifdef SUB64_BORROW_OUT_EN
    assign bus.borrow   = borrow_q;
`endif

endmodule

// File: tb/tb_sub64_seq.sv
// Scoreboard bench for sub64_seq: driver pushes reference results, a negedge
// monitor pops and compares them whenever done is high.
module tb_sub64_seq;
    import alu_pkg::*;

    localparam int W = 64;
    localparam int D = 8;
    localparam int N = W / D;

    typedef struct {
        logic [63:0] diff;
        logic        ovf;
        logic        zf;
        logic        sf;
        logic        brw;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub64_seq_if #(.WIDTH(W)) bus ();

    sub64_seq #(
        .WIDTH   (W),
        .DIGIT_W (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the full operands.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int c);
        exp_t e;
        logic signed [64:0] full;
        full   = $signed({a[63], a}) - $signed({b[63], b});
        e.diff = a - b;
        e.ovf  = (full > 65'sd9223372036854775807) || (full < -65'sd9223372036854775808);
        e.zf   = (a == b);
        e.sf   = full[63];
        e.brw  = (a < b);
        e.cyc  = c;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (diff=%h)", bus.diff);
            end else begin
                e = sb.pop_front();
                chk("diff", bus.diff, e.diff);
                chk("overflow", 64'(bus.overflow), 64'(e.ovf));
                chk("zf", 64'(bus.zf), 64'(e.zf));
                chk("sf", 64'(bus.sf), 64'(e.sf));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
`ifdef SUB64_BORROW_OUT_EN
                chk("borrow", 64'(bus.borrow), 64'(e.brw));
`endif
            end
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Called and returning on a negedge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 40 cycles");
        end
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(model(a, b, cyc + 1 + N));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = rnd64();
        bus.b     = rnd64();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_diff"}, bus.diff, 64'd0);
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
        chk({tag, "_zf"}, 64'(bus.zf), 64'd0);
        chk({tag, "_sf"}, 64'(bus.sf), 64'd0);
`ifdef SUB64_BORROW_OUT_EN
        chk({tag, "_borrow"}, 64'(bus.borrow), 64'd0);
`endif
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        seen;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Signed overflow corners.
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        issue(64'h8000_0000_0000_0000, 64'd1);
        drain();

        // Zero and small negative results.
        issue(64'd23, 64'd23);
        drain();
        issue(-64'sd2, 64'd13);
        drain();

        // Start while running must be ignored.
        issue(64'd2, 64'd13);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'd5;
        bus.b     = 64'd5;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // Reset mid-operation aborts with no done.
        bus.start = 1'b1;
        bus.a     = 64'd9;
        bus.b     = -64'sd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(64'd9, -64'sd9);
        drain();

        // Start in the done cycle is accepted.
        issue(rnd64(), rnd64());
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL b2b_done_timeout: got no done expected done within 40 cycles");
        end
        bus.start = 1'b1;
        bus.a     = 64'd0;
        bus.b     = 64'd0;
        sb.push_back(model(64'd0, 64'd0, cyc + 1 + N));
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Random traffic, mixing drained and back-to-back requests.
        for (int i = 0; i < 24; i++) begin
            ra = rnd64();
            rb = (i % 5 == 0) ? ra : rnd64();
            if (i % 7 == 3) ra[63] = ~rb[63];
            issue(ra, rb);
            if ($urandom_range(1, 0) == 1) drain();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
